// File: rtl/fire_ctrl_salvo.sv
// Salvo fire controller: qualifies a locked, moving target inside a per-axis strike window,
// then issues round-robin one-cycle fire pulses. Optional dwell gating: FIRE_CTRL_DWELL_EN.
module fire_ctrl_salvo #(
    parameter int W               = 16,
    parameter int NUM_LAUNCHERS   = 4,
    parameter int STRIKE_TOLERANCE = 3,
    parameter int DWELL_CYCLES    = 4,
    parameter int SALVO_LEN       = 2,
    parameter int SALVO_GAP       = 3,
    parameter int COOLDOWN_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     lock_active,
    input  logic                     target_moving,
    input  logic [W-1:0]             x_curr,
    input  logic [W-1:0]             y_curr,
    input  logic [W-1:0]             z_curr,
    input  logic [W-1:0]             x_pred,
    input  logic [W-1:0]             y_pred,
    input  logic [W-1:0]             z_pred,
    input  logic [NUM_LAUNCHERS-1:0] launcher_ready,
    output logic [NUM_LAUNCHERS-1:0] fire_pulse,
    output logic                     salvo_done,
    output logic                     salvo_abort,
    output logic                     busy,
    output logic [15:0]              shots_fired,
    output logic [2:0]               state_dbg
);

    localparam int PW = (NUM_LAUNCHERS > 1) ? $clog2(NUM_LAUNCHERS) : 1;
    localparam int GW = $clog2(SALVO_GAP + 1);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [W-1:0]  TOL        = W'(STRIKE_TOLERANCE);
    localparam logic [GW-1:0] GAP_MAX    = GW'(SALVO_GAP);
    localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [3:0]    SALVO_LAST = 4'(SALVO_LEN);
    localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_LAUNCHERS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DWELL    = 3'd1,
        S_GAP      = 3'd2,
        S_COOLDOWN = 3'd3,
        S_REARM    = 3'd4
    } state_t;

    state_t                   state, state_n;
    logic [NUM_LAUNCHERS-1:0] fire_n;
    logic                     done_n, abort_n, busy_n;
    logic [15:0]              shots_n;
    logic [3:0]               shot_cnt, shot_n, shot_base, shot_inc;
    logic [GW-1:0]            gap_cnt, gap_n;
    logic [CW-1:0]            cool_cnt, cool_n;
    logic [PW-1:0]            rr_ptr, rr_n, sel;
    logic [PW:0]              idx;
    logic [NUM_LAUNCHERS-1:0] sel_onehot;
    logic                     found, any_ready, in_window, qualify, do_fire;
    logic [W-1:0]             dx, dy, dz;

`ifdef FIRE_CTRL_DWELL_EN
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES);
    logic [DW-1:0] dwell_cnt, dwell_n, dwell_sat;
`endif

    // Valid/ready contract: a pulse on fire_pulse[i] is issued only while launcher_ready[i]
    // is sampled high on the same edge; launchers never back-pressure an issued pulse.

    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign dx        = abs_diff(x_curr, x_pred);
    assign dy        = abs_diff(y_curr, y_pred);
    assign dz        = abs_diff(z_curr, z_pred);
    assign in_window = (dx <= TOL) && (dy <= TOL) && (dz <= TOL);
    assign qualify   = lock_active && target_moving && in_window;
    assign any_ready = |launcher_ready;
    assign state_dbg = state;

    // Circular first-set search starting at rr_ptr.
    always_comb begin
        sel        = '0;
        found      = 1'b0;
        idx        = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_LAUNCHERS; i++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NUM_LAUNCHERS))
                idx = idx - (PW+1)'(NUM_LAUNCHERS);
            if (!found && launcher_ready[idx[PW-1:0]]) begin
                found = 1'b1;
                sel   = idx[PW-1:0];
            end
        end
        sel_onehot[sel] = 1'b1;
    end

    always_comb begin
        state_n   = state;
        fire_n    = '0;
        done_n    = 1'b0;
        abort_n   = 1'b0;
        shots_n   = shots_fired;
        shot_n    = shot_cnt;
        gap_n     = gap_cnt;
        cool_n    = cool_cnt;
        rr_n      = rr_ptr;
        do_fire   = 1'b0;
        shot_base = ((state == S_IDLE) || (state == S_DWELL)) ? 4'd0 : shot_cnt;
        shot_inc  = shot_base + 4'd1;
`ifdef FIRE_CTRL_DWELL_EN
        dwell_n   = dwell_cnt;
        dwell_sat = (dwell_cnt == DWELL_MAX) ? dwell_cnt : dwell_cnt + 1'b1;
`endif
        case (state)
            S_IDLE: begin
                shot_n = '0;
`ifdef FIRE_CTRL_DWELL_EN
                if (qualify) begin
                    if (DWELL_CYCLES == 1 && any_ready) begin
                        do_fire = 1'b1;
                    end else begin
                        state_n = S_DWELL;
                        dwell_n = DW'(1);
                    end
                end
`else
                if (qualify && any_ready)
                    do_fire = 1'b1;
`endif
            end
`ifdef FIRE_CTRL_DWELL_EN
            S_DWELL: begin
                if (!qualify) begin
                    state_n = S_IDLE;
                    dwell_n = '0;
                end else begin
                    dwell_n = dwell_sat;
                    if (dwell_sat == DWELL_MAX && any_ready)
                        do_fire = 1'b1;
                end
            end
`endif
            S_GAP: begin
                // Lock loss takes priority over a shot that is due on the same edge.
                if (!lock_active) begin
                    abort_n = 1'b1;
                    state_n = S_COOLDOWN;
                    cool_n  = '0;
                end else if (gap_cnt != GAP_MAX) begin
                    gap_n = gap_cnt + 1'b1;
                end else if (any_ready) begin
                    do_fire = 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (cool_cnt == COOL_LAST)
                    state_n = S_REARM;
                else
                    cool_n = cool_cnt + 1'b1;
            end
            S_REARM: begin
                if (!in_window || !lock_active)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (do_fire) begin
            fire_n  = sel_onehot;
            rr_n    = (sel == PTR_LAST) ? '0 : sel + 1'b1;
            shots_n = (shots_fired == 16'hFFFF) ? shots_fired : shots_fired + 16'd1;
            shot_n  = shot_inc;
            gap_n   = '0;
`ifdef FIRE_CTRL_DWELL_EN
            dwell_n = '0;
`endif
            if (shot_inc < SALVO_LAST) begin
                state_n = S_GAP;
            end else begin
                done_n  = 1'b1;
                state_n = S_COOLDOWN;
                cool_n  = '0;
            end
        end

        busy_n = (state_n == S_GAP) || (state_n == S_COOLDOWN) || (state_n == S_REARM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            fire_pulse  <= '0;
            salvo_done  <= 1'b0;
            salvo_abort <= 1'b0;
            busy        <= 1'b0;
            shots_fired <= '0;
            shot_cnt    <= '0;
            gap_cnt     <= '0;
            cool_cnt    <= '0;
            rr_ptr      <= '0;
`ifdef FIRE_CTRL_DWELL_EN
            dwell_cnt   <= '0;
`endif
        end else begin
            state       <= state_n;
            fire_pulse  <= fire_n;
            salvo_done  <= done_n;
            salvo_abort <= abort_n;
            busy        <= busy_n;
            shots_fired <= shots_n;
            shot_cnt    <= shot_n;
            gap_cnt     <= gap_n;
            cool_cnt    <= cool_n;
            rr_ptr      <= rr_n;
`ifdef FIRE_CTRL_DWELL_EN
            dwell_cnt   <= dwell_n;
`endif
        end
    end

endmodule

// File: tb/tb_fire_ctrl_salvo.sv
// Scoreboard bench for fire_ctrl_salvo: expected pulse/done/abort events, tagged with the
// cycle they must appear on, are queued as stimulus is driven and popped as the DUT emits them.
module tb_fire_ctrl_salvo;

    localparam int W    = 16;
    localparam int N    = 4;
    localparam int GAP  = 3;
    localparam int COOL = 16;
`ifdef FIRE_CTRL_DWELL_EN
    localparam int LAT  = 4;
`else
    localparam int LAT  = 1;
`endif
    localparam logic [31:0] ST_IDLE  = 32'd0;
    localparam logic [31:0] ST_COOL  = 32'd3;
    localparam logic [31:0] ST_REARM = 32'd4;

    logic          clk = 1'b0;
    logic          reset;
    logic          lock_active, target_moving;
    logic [W-1:0]  x_curr, y_curr, z_curr, x_pred, y_pred, z_pred;
    logic [N-1:0]  launcher_ready;
    logic [N-1:0]  fire_pulse;
    logic          salvo_done, salvo_abort, busy;
    logic [15:0]   shots_fired;
    logic [2:0]    state_dbg;

    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    int            exp_shots = 0;
    logic [31:0]   exp_q[$];

    fire_ctrl_salvo dut (
        .clk(clk), .reset(reset),
        .lock_active(lock_active), .target_moving(target_moving),
        .x_curr(x_curr), .y_curr(y_curr), .z_curr(z_curr),
        .x_pred(x_pred), .y_pred(y_pred), .z_pred(z_pred),
        .launcher_ready(launcher_ready),
        .fire_pulse(fire_pulse), .salvo_done(salvo_done), .salvo_abort(salvo_abort),
        .busy(busy), .shots_fired(shots_fired), .state_dbg(state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Event word: {cycle[15:0], 10'b0, fire_pulse, salvo_done, salvo_abort}
    task automatic expect_ev(input int at, input logic [3:0] p, input logic d, input logic a);
        exp_q.push_back({16'(at), 10'b0, p, d, a});
        if (p != 4'd0) exp_shots++;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic place(input int dx, input int dy, input int dz);
        int bx, by, bz;
        bx = $urandom_range(100, 60000);
        by = $urandom_range(100, 60000);
        bz = $urandom_range(100, 60000);
        x_pred = 16'(bx); x_curr = 16'(bx + dx);
        y_pred = 16'(by); y_curr = 16'(by + dy);
        z_pred = 16'(bz); z_curr = 16'(bz + dz);
    endtask

    task automatic check_drained(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [31:0] obs;
        if (!reset && (fire_pulse != '0 || salvo_done || salvo_abort)) begin
            obs = {cyc[15:0], 10'b0, fire_pulse, salvo_done, salvo_abort};
            if (exp_q.size() == 0) check("unexpected_event", obs, 32'd0);
            else                   check("event", obs, exp_q.pop_front());
        end
    end

    initial begin
        int k, p;
        reset = 1'b1;
        lock_active = 1'b0;
        target_moving = 1'b0;
        launcher_ready = 4'hF;
        place(0, 0, 0);
        step(2);
        check("rst_fire", 32'(fire_pulse), 32'd0);
        check("rst_done", 32'(salvo_done), 32'd0);
        check("rst_abort", 32'(salvo_abort), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_shots", 32'(shots_fired), 32'd0);
        check("rst_state", 32'(state_dbg), ST_IDLE);
        reset = 1'b0;
        step(1);

        // Full salvo, tolerance boundary on both sides, qualify held
        place(3, -3, 2);
        lock_active = 1'b1;
        target_moving = 1'b1;
        k = cyc;
        expect_ev(k + LAT, 4'b0001, 1'b0, 1'b0);
        expect_ev(k + LAT + GAP + 1, 4'b0010, 1'b1, 1'b0);
        step(LAT + GAP + 2);
        check_drained("salvo1_drain");
        check("salvo1_shots", 32'(shots_fired), 32'(exp_shots));
        step(COOL + 4);
        check("rearm_hold_state", 32'(state_dbg), ST_REARM);
        check("rearm_hold_busy", 32'(busy), 32'd1);
        place(4, 0, 0);
        step(1);
        check("rearm_exit_state", 32'(state_dbg), ST_IDLE);
        check("rearm_exit_busy", 32'(busy), 32'd0);
        step(6);
        place(-1, 0, -3);
        k = cyc;
        expect_ev(k + LAT, 4'b0100, 1'b0, 1'b0);
        expect_ev(k + LAT + GAP + 1, 4'b1000, 1'b1, 1'b0);
        step(LAT + GAP + 2);
        check_drained("salvo2_drain");
        check("salvo2_shots", 32'(shots_fired), 32'(exp_shots));
        lock_active = 1'b0;
        step(COOL + 4);
        check("salvo2_idle", 32'(state_dbg), ST_IDLE);

`ifdef FIRE_CTRL_DWELL_EN
        // Broken dwell restarts the count
        place(0, 1, 0);
        lock_active = 1'b1;
        step(3);
        target_moving = 1'b0;
        step(1);
        target_moving = 1'b1;
        k = cyc;
        expect_ev(k + 4, 4'b0001, 1'b0, 1'b0);
        expect_ev(k + 4 + GAP + 1, 4'b0010, 1'b1, 1'b0);
        step(4 + GAP + 2);
        check_drained("dwell_restart_drain");
        lock_active = 1'b0;
        step(COOL + 4);
`endif

        // Round-robin from rr_ptr=0 with sparse ready masks
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        exp_shots = 0;
        launcher_ready = 4'b0100;
        place(1, 1, 1);
        lock_active = 1'b1;
        target_moving = 1'b1;
        k = cyc;
        expect_ev(k + LAT, 4'b0100, 1'b0, 1'b0);
        step(LAT);
        launcher_ready = 4'b1001;
        expect_ev(k + LAT + GAP + 1, 4'b1000, 1'b1, 1'b0);
        step(GAP + 2);
        check_drained("rr_drain");
        check("rr_shots", 32'(shots_fired), 32'(exp_shots));
        lock_active = 1'b0;
        step(COOL + 4);

        // Lock loss during GAP aborts the salvo
        launcher_ready = 4'hF;
        place(0, 2, 0);
        lock_active = 1'b1;
        k = cyc;
        p = k + LAT;
        expect_ev(p, 4'b0001, 1'b0, 1'b0);
        expect_ev(p + 1, 4'b0000, 1'b0, 1'b1);
        step(LAT);
        lock_active = 1'b0;
        step(16);
        check("abort_cool_state", 32'(state_dbg), ST_COOL);
        check("abort_cool_busy", 32'(busy), 32'd1);
        step(1);
        check("abort_rearm_state", 32'(state_dbg), ST_REARM);
        step(1);
        check("abort_idle_state", 32'(state_dbg), ST_IDLE);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check_drained("abort_drain");
        check("abort_shots", 32'(shots_fired), 32'(exp_shots));

        // No launcher ready: hold, then fire on the first ready edge
        launcher_ready = 4'b0000;
        place(0, 0, -2);
        lock_active = 1'b1;
        step(8);
        launcher_ready = 4'b0010;
        k = cyc;
        expect_ev(k + 1, 4'b0010, 1'b0, 1'b0);
        expect_ev(k + 1 + GAP + 1, 4'b0010, 1'b1, 1'b0);
        step(GAP + 3);
        check_drained("noready_drain");
        lock_active = 1'b0;
        step(COOL + 4);

        // Reset during GAP clears everything at once
        launcher_ready = 4'hF;
        place(2, 0, 0);
        lock_active = 1'b1;
        k = cyc;
        expect_ev(k + LAT, 4'b0100, 1'b0, 1'b0);
        step(LAT + 1);
        check_drained("pre_reset_drain");
        reset = 1'b1;
        #1;
        check("midrst_fire", 32'(fire_pulse), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_shots", 32'(shots_fired), 32'd0);
        check("midrst_state", 32'(state_dbg), ST_IDLE);
        exp_shots = 0;
        step(2);
        reset = 1'b0;
        k = cyc;
        expect_ev(k + LAT, 4'b0001, 1'b0, 1'b0);
        expect_ev(k + LAT + GAP + 1, 4'b0010, 1'b1, 1'b0);
        step(LAT + GAP + 2);
        check_drained("post_reset_drain");
        check("post_reset_shots", 32'(shots_fired), 32'(exp_shots));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fire_ctrl_salvo.md
# fire_ctrl_salvo

Parametrised multi-launcher fire controller; next generation of the single-pulse fire controller. Qualifies a locked, moving target against a per-axis strike window and requires a dwell period. It then issues a salvo of one-cycle fire pulses, distributed round-robin across ready launchers. A cooldown follows each salvo, and the block re-arms only after the target leaves the window or lock drops. Sits between lock_fsm/tracker_core and the launcher interface.

## Interface
- W, 16: coordinate width (unsigned).
- NUM_LAUNCHERS, 4: launcher channels, 1..16.
- STRIKE_TOLERANCE, 3: max per-axis |curr−pred|, inclusive.
- DWELL_CYCLES, 4: consecutive qualifying samples before first shot, ≥1.
- SALVO_LEN, 2: pulses per salvo, 1..15.
- SALVO_GAP, 3: idle cycles between pulses in a salvo, ≥1.
- COOLDOWN_CYCLES, 16: cycles after salvo end/abort before re-arm check, ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- lock_active  in  1  from lock_fsm.
- target_moving  in  1  from tracker_core.
- x_curr, y_curr, z_curr  in  W each  current position.
- x_pred, y_pred, z_pred  in  W each  predicted position.
- launcher_ready  in  NUM_LAUNCHERS  per-launcher ready mask.
- fire_pulse  out  NUM_LAUNCHERS  one-hot single-cycle fire, else zero.
- salvo_done  out  1  one-cycle pulse after last shot of a full salvo.
- salvo_abort  out  1  one-cycle pulse when a salvo is cut short.
- busy  out  1  high in GAP, COOLDOWN, REARM.
- shots_fired  out  16  total pulses issued, saturates at 0xFFFF.

## Operation
- Per-axis delta is unsigned abs difference in W bits with no overflow. in_window = all three deltas ≤ STRIKE_TOLERANCE.
- qualify = lock_active & target_moving & in_window.
- Launcher select: circular search from rr_ptr for the first set bit of launcher_ready. After a shot, rr_ptr = sel+1 mod NUM_LAUNCHERS. Shot issues only if launcher_ready is nonzero.
- States:
  - IDLE: on qualify, if dwell is satisfied (DWELL_CYCLES==1) and a launcher is ready, fire; otherwise go to DWELL with dwell_cnt=1.
  - DWELL: on !qualify, return to IDLE and clear dwell_cnt. On qualify, increment dwell_cnt, saturating at DWELL_CYCLES. Fire when dwell_cnt has reached DWELL_CYCLES and a launcher is ready; with no launcher ready, hold in DWELL.
  - FIRE action (registered): fire_pulse <= one-hot(sel), shot_cnt++, shots_fired++. Next state is GAP if shot_cnt < SALVO_LEN; otherwise assert salvo_done and go to COOLDOWN.
  - GAP: counts SALVO_GAP cycles, then fires when a launcher is ready, waiting otherwise. Window/motion are not re-checked mid-salvo.
  - Lock loss: lock_active low on any GAP cycle asserts salvo_abort and goes to COOLDOWN.
  - COOLDOWN: counts COOLDOWN_CYCLES, then goes to REARM.
  - REARM: go to IDLE on (!in_window | !lock_active). This prevents re-engaging the same sighting.
- Simultaneous lock loss and gap expiry: abort wins, no pulse.
- Reset mid-salvo: all state cleared immediately. No pulse is emitted for the cycle reset is asserted.

## Timing
- Reset values: fire_pulse=0, salvo_done=0, salvo_abort=0, busy=0, shots_fired=0, rr_ptr=0, state=IDLE, all counters 0.
- All outputs are registered.
- First-shot latency: fire_pulse is high in the cycle following the DWELL_CYCLES-th consecutive rising edge with qualify=1 and a launcher ready.
- Inter-pulse spacing in a salvo is SALVO_GAP+1 cycles (pulse-edge to pulse-edge) when launchers stay ready.
- salvo_done is coincident with the final fire_pulse.
- salvo_abort is coincident with the cycle after the lock-loss sample.
- busy rises with the first pulse of a salvo and falls on entry to IDLE.

## Configuration
- FIRE_CTRL_DWELL_EN:
  - Defined: DWELL state and dwell_cnt are present as described.
  - Undefined: DWELL is removed and DWELL_CYCLES is ignored. IDLE fires on the first edge where qualify=1 and a launcher is ready, so first-shot latency is one cycle.

## Test plan
- Defaults, all ready, qualify held high → fire_pulse=0001 four cycles after qualify rises, 0010 four cycles later, salvo_done with second pulse, shots_fired=2.
- Qualify high 3 cycles, low 1, high again → no pulse until 4 further consecutive qualifying edges.
- launcher_ready=0100, rr_ptr=0 → first pulse 0100, rr_ptr=3. Then ready=1001 → second pulse 1000.
- lock_active drops during GAP after first pulse → salvo_abort 1 cycle, no second pulse, COOLDOWN 16 cycles, REARM exits immediately to IDLE.
- Target stays in window after cooldown → block stays in REARM with no pulses. Moving x_curr out by 4 → IDLE; returning refires after dwell.
- Assert reset during GAP → all outputs 0 immediately. After release, a fresh dwell is required; without FIRE_CTRL_DWELL_EN, the pulse is one cycle after qualify.
